// File: rtl/output_port_stage.sv
// ---------------------------------------------------------------------------
// output_port_stage
//
// Per-port transmit stage of the VC router. It takes flits from the crossbar
// that already carry their allocated output VC, rewrites the flit VC field,
// and registers the flit onto the valid/data/ready link toward the
// neighbour's input port. It keeps per-VC credit counters for the
// downstream buffers and per-VC ownership state for the VC allocator.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        crossbar flit valid
//   in_data         crossbar flit
//   in_vc           output VC allocated to this flit
//   in_ready        flit accepted this cycle when in_valid is also high
//   alloc_valid     VC allocator claims output VC alloc_vc
//   alloc_vc        VC being claimed
//   vc_free         per-VC "unowned" flags (registered)
//   vc_has_credit   per-VC "credit > 0" flags (registered)
//   credit_in       per-VC one-cycle credit return pulses from downstream
//   valid, data     link flit valid / flit
//   ready           link ready from downstream
//   err             sticky protocol-violation flag, cleared only by rst
//
// Flit layout: [DW-1:DW-2] type (10 head, 00 body, 01 tail, 11 head-tail),
//              [DW-3:DW-4] VC id.
// ---------------------------------------------------------------------------
module output_port_stage #(
    parameter int DW            = 32,
    parameter int V             = 4,
    parameter int BUF_DEPTH     = 4,
    parameter int BUF_DEPTH_LOG = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_vc,
    output logic          in_ready,
    input  logic          alloc_valid,
    input  logic [1:0]    alloc_vc,
    output logic [V-1:0]  vc_free,
    output logic [V-1:0]  vc_has_credit,
    input  logic [V-1:0]  credit_in,
    output logic          valid,
    output logic [DW-1:0] data,
    input  logic          ready,
    output logic          err
);

    localparam int            CW         = BUF_DEPTH_LOG + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(BUF_DEPTH);

    typedef enum logic {
        VC_FREE  = 1'b0,
        VC_OWNED = 1'b1
    } vc_state_e;

    // Link output register
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          err_q,   err_d;

    // Per-VC status gathered from the generate blocks
    logic [V-1:0]  free_vec;
    logic [V-1:0]  has_credit_vec;
    logic [V-1:0]  alloc_err_vec;
    logic [V-1:0]  ovf_err_vec;

    logic          sel_free;
    logic          sel_credit;
    logic          accept;
    logic          is_tail;

    // Look up the status of the VC addressed by in_vc. A VC id beyond V is
    // treated as a free VC, so it is never accepted and flags an error.
    always_comb begin
        sel_free   = 1'b1;
        sel_credit = 1'b0;
        for (int v = 0; v < V; v++) begin
            if (in_vc == 2'(v)) begin
                sel_free   = free_vec[v];
                sel_credit = has_credit_vec[v];
            end
        end
    end

    assign in_ready = (~valid_q | ready) & ~sel_free & sel_credit;
    assign accept   = in_valid & in_ready;
    // Tail and head-tail both have the low type bit set.
    assign is_tail  = in_data[DW-2];

    // -----------------------------------------------------------------------
    // Per-VC ownership FSM and credit counter
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < V; gi++) begin : g_vc
            localparam logic [1:0] VC_ID = 2'(gi);

            logic          acc_here;
            logic          alloc_here;
            logic          credit_here;
            vc_state_e     state_q, state_d;
            logic [CW-1:0] credit_q, credit_d;
            logic          has_credit_q;
            logic          alloc_err;
            logic          ovf_err;

            assign acc_here    = accept & (in_vc == VC_ID);
            assign alloc_here  = alloc_valid & (alloc_vc == VC_ID);
            assign credit_here = credit_in[gi];

            // Ownership: a claim on an owned VC (including one whose tail is
            // leaving this very cycle) is ignored and reported.
            always_comb begin
                state_d   = state_q;
                alloc_err = 1'b0;
                case (state_q)
                    VC_FREE: begin
                        if (alloc_here) begin
                            state_d = VC_OWNED;
                        end
                    end
                    VC_OWNED: begin
                        if (acc_here && is_tail) begin
                            state_d = VC_FREE;
                        end
                        if (alloc_here) begin
                            alloc_err = 1'b1;
                        end
                    end
                    default: begin
                        state_d = VC_FREE;
                    end
                endcase
            end

            // Credits: a send and a return in the same cycle cancel out. A
            // return with the counter already full saturates and is reported.
            always_comb begin
                credit_d = credit_q;
                ovf_err  = 1'b0;
                if (acc_here && !credit_here) begin
                    credit_d = credit_q - CW'(1);
                end else if (credit_here && !acc_here) begin
                    if (credit_q == CREDIT_MAX) begin
                        ovf_err = 1'b1;
                    end else begin
                        credit_d = credit_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q      <= VC_FREE;
                    credit_q     <= CREDIT_MAX;
                    has_credit_q <= 1'b1;
                end else begin
                    state_q      <= state_d;
                    credit_q     <= credit_d;
                    has_credit_q <= (credit_d != '0);
                end
            end

            assign free_vec[gi]       = (state_q == VC_FREE);
            assign has_credit_vec[gi] = has_credit_q;
            assign alloc_err_vec[gi]  = alloc_err;
            assign ovf_err_vec[gi]    = ovf_err;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Link register: loads on accept, drains on ready, holds under stall.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            valid_d             = 1'b1;
            data_d              = in_data;
            data_d[DW-3:DW-4]   = in_vc;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    // A flit offered to a VC nobody owns is a protocol violation.
    always_comb begin
        err_d = err_q | (|alloc_err_vec) | (|ovf_err_vec) | (in_valid & sel_free);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign valid         = valid_q;
    assign data          = data_q;
    assign err           = err_q;
    assign vc_free       = free_vec;
    assign vc_has_credit = has_credit_vec;

endmodule

// File: tb/tb_output_port_stage.sv
// ---------------------------------------------------------------------------
// tb_output_port_stage
//
// Self-checking bench for output_port_stage. Every flit the bench expects to
// be accepted is pushed (with its VC field rewritten) onto a scoreboard
// queue; a link monitor pops and compares each flit that leaves on the link.
// ---------------------------------------------------------------------------
module tb_output_port_stage;

    localparam int DW = 32;
    localparam int V  = 4;

    localparam logic [1:0] HEAD  = 2'b10;
    localparam logic [1:0] BODY  = 2'b00;
    localparam logic [1:0] TAIL  = 2'b01;
    localparam logic [1:0] HTAIL = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_vc;
    logic          in_ready;
    logic          alloc_valid;
    logic [1:0]    alloc_vc;
    logic [V-1:0]  vc_free;
    logic [V-1:0]  vc_has_credit;
    logic [V-1:0]  credit_in;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          err;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];

    output_port_stage #(
        .DW           (DW),
        .V            (V),
        .BUF_DEPTH    (4),
        .BUF_DEPTH_LOG(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_vc        (in_vc),
        .in_ready     (in_ready),
        .alloc_valid  (alloc_valid),
        .alloc_vc     (alloc_vc),
        .vc_free      (vc_free),
        .vc_has_credit(vc_has_credit),
        .credit_in    (credit_in),
        .valid        (valid),
        .data         (data),
        .ready        (ready),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Link monitor: a transfer happens on the next rising edge when valid
    // and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("link_unexpected", {32'h0, data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("link_data", {32'h0, data}, {32'h0, exp_q.pop_front()});
            end
            $display("link flit %h", data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        alloc_valid = 1'b0;
        credit_in   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        in_data = '0;
        in_vc   = 2'd0;
        alloc_vc = 2'd0;
        ready   = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] vc);
        alloc_valid = 1'b1;
        alloc_vc    = vc;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic pulse(input logic [V-1:0] mask);
        credit_in = mask;
        tick();
        credit_in = '0;
    endtask

    // Offer one flit for one cycle; the in_data VC field is deliberately 01
    // so the rewrite to in_vc is visible on the link.
    task automatic offer(input string tag, input logic [1:0] vc, input logic [1:0] ty,
                         input logic [27:0] pl, input logic exp_rdy);
        in_valid = 1'b1;
        in_vc    = vc;
        in_data  = {ty, 2'b01, pl};
        @(negedge clk);
        check(tag, {63'h0, in_ready}, {63'h0, exp_rdy});
        if (exp_rdy) begin
            exp_q.push_back({ty, vc, pl});
        end
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_valid", {63'h0, valid}, 64'h0);
        check("rst_data", {32'h0, data}, 64'h0);
        check("rst_free", {60'h0, vc_free}, 64'hF);
        check("rst_credit", {60'h0, vc_has_credit}, 64'hF);
        check("rst_err", {63'h0, err}, 64'h0);

        // Packet on VC2
        alloc(2'd2);
        check("t1_free_alloc", {60'h0, vc_free}, 64'hB);
        offer("t1_head", 2'd2, HEAD, 28'h00000A1, 1'b1);
        check("t1_valid_h", {63'h0, valid}, 64'h1);
        offer("t1_body", 2'd2, BODY, 28'h00000A2, 1'b1);
        check("t1_valid_b", {63'h0, valid}, 64'h1);
        check("t1_free_mid", {60'h0, vc_free}, 64'hB);
        offer("t1_tail", 2'd2, TAIL, 28'h00000A3, 1'b1);
        idle();
        check("t1_valid_t", {63'h0, valid}, 64'h1);
        check("t1_free_tail", {60'h0, vc_free}, 64'hF);
        // Last of four credits on VC2
        alloc(2'd2);
        offer("t1_last_credit", 2'd2, HTAIL, 28'h00000A4, 1'b1);
        idle();
        check("t1_credit_zero", {60'h0, vc_has_credit}, 64'hB);

        // Stream five flits on VC0 with no credit returns
        alloc(2'd0);
        for (int i = 0; i < 5; i++) begin
            offer("t2_stream", 2'd0, (i == 0) ? HEAD : BODY, 28'(32'h100 + i), i < 4);
        end
        check("t2_no_credit", {63'h0, vc_has_credit[0]}, 64'h0);
        credit_in = 4'b0001;
        @(negedge clk);
        check("t2_stall_pulse", {63'h0, in_ready}, 64'h0);
        tick();
        credit_in = '0;
        offer("t2_fifth", 2'd0, BODY, 28'h104, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) pulse(4'b0001);
        offer("t2_tail", 2'd0, TAIL, 28'h105, 1'b1);
        idle();
        pulse(4'b0001);
        check("t2_free", {60'h0, vc_free}, 64'hF);
        check("t2_err", {63'h0, err}, 64'h0);

        // Backpressure on VC1
        alloc(2'd1);
        offer("t3_head", 2'd1, HEAD, 28'h200, 1'b1);
        ready    = 1'b0;
        in_valid = 1'b1;
        in_vc    = 2'd1;
        in_data  = {BODY, 2'b01, 28'h201};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_stall_ready", {63'h0, in_ready}, 64'h0);
            check("t3_stall_data", {32'h0, data}, {32'h0, HEAD, 2'b01, 28'h200});
            check("t3_stall_valid", {63'h0, valid}, 64'h1);
            tick();
        end
        ready = 1'b1;
        offer("t3_release", 2'd1, BODY, 28'h201, 1'b1);
        check("t3_valid_new", {63'h0, valid}, 64'h1);
        check("t3_data_new", {32'h0, data}, {32'h0, BODY, 2'b01, 28'h201});

        // Send and credit return on VC1 in the same cycle, credit[1] = 2
        credit_in = 4'b0010;
        offer("t4_simul", 2'd1, BODY, 28'h202, 1'b1);
        credit_in = '0;
        offer("t4_b3", 2'd1, BODY, 28'h203, 1'b1);
        offer("t4_b4", 2'd1, BODY, 28'h204, 1'b1);
        offer("t4_b5_stall", 2'd1, BODY, 28'h205, 1'b0);
        idle();
        check("t4_no_credit", {63'h0, vc_has_credit[1]}, 64'h0);
        pulse(4'b0010);
        offer("t4_tail", 2'd1, TAIL, 28'h205, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) pulse(4'b0010);
        check("t4_err_clean", {63'h0, err}, 64'h0);
        // Credit return on a full VC3 counter
        pulse(4'b1000);
        check("t4_ovf_err", {63'h0, err}, 64'h1);
        check("t4_ovf_credit", {60'h0, vc_has_credit}, 64'hB);
        alloc(2'd3);
        for (int i = 0; i < 5; i++) begin
            offer("t4_sat", 2'd3, (i == 0) ? HEAD : BODY, 28'(32'h300 + i), i < 4);
        end
        idle();
        tick();
        tick();

        // Error cases
        do_reset();
        check("t5_err_rst", {63'h0, err}, 64'h0);
        alloc(2'd1);
        check("t5_alloc_once", {63'h0, err}, 64'h0);
        alloc(2'd1);
        check("t5_alloc_twice", {63'h0, err}, 64'h1);
        do_reset();
        offer("t5_free_vc", 2'd3, HEAD, 28'h400, 1'b0);
        idle();
        check("t5_free_err", {63'h0, err}, 64'h1);
        tick();
        tick();
        tick();
        check("t5_sticky", {63'h0, err}, 64'h1);
        do_reset();
        check("t5_cleared", {63'h0, err}, 64'h0);

        // Reset with a flit stuck in the link register
        alloc(2'd0);
        offer("t6_head", 2'd0, HEAD, 28'h500, 1'b1);
        ready = 1'b0;
        idle();
        check("t6_held", {63'h0, valid}, 64'h1);
        rst = 1'b1;
        tick();
        check("t6_valid", {63'h0, valid}, 64'h0);
        check("t6_free", {60'h0, vc_free}, 64'hF);
        check("t6_credit", {60'h0, vc_has_credit}, 64'hF);
        exp_q.delete();
        rst   = 1'b0;
        ready = 1'b1;
        alloc(2'd0);
        for (int i = 0; i < 5; i++) begin
            offer("t6_reload", 2'd0, (i == 0) ? HEAD : BODY, 28'(32'h600 + i), i < 4);
        end
        idle();
        tick();
        tick();

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/output_port_stage.md
Name: output_port_stage

Overview:
- Per-port transmit stage of the VC router: the upstream sender that drives the valid/data/ready link into a neighbour's per-VC-buffered input port stage.
- Accepts flits from the crossbar already tagged with their allocated output VC. Rewrites the flit's VC field and registers the flit onto the link.
- Tracks downstream free buffer slots per VC with credit counters. Tracks which output VCs are owned by a packet; this ownership feeds the VC allocator.

Parameters:
- DW, 32: flit width. Flit fields: [DW-1:DW-2] type (2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 head-tail); [DW-3:DW-4] VC id.
- V, 4: number of VCs per port. The VC field is fixed at 2 bits, so V must not exceed 4.
- BUF_DEPTH, 4: downstream per-VC buffer depth, which is also the initial credit count.
- BUF_DEPTH_LOG, 2: log2(BUF_DEPTH). Credit counters are BUF_DEPTH_LOG+1 bits wide.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  crossbar flit valid.
- in_data  in  DW  crossbar flit.
- in_vc  in  2  output VC allocated to this flit.
- in_ready  out  1  flit accepted this cycle when in_valid is also high.
- alloc_valid  in  1  VC allocator claims output VC alloc_vc.
- alloc_vc  in  2  VC being claimed.
- vc_free  out  V  registered; bit v high means VC v is unowned.
- vc_has_credit  out  V  registered; bit v high means credit[v] is greater than 0. Consumed by the switch allocator.
- credit_in  in  V  one-cycle pulses from downstream; bit v pulses when one slot of VC v is freed.
- valid  out  1  link flit valid.
- data  out  DW  link flit.
- ready  in  1  link ready from downstream.
- err  out  1  sticky protocol-violation flag, cleared only by rst.

Behaviour:
- Reset values: valid=0, data=0, vc_free all 1, every credit[v]=BUF_DEPTH (so vc_has_credit all 1), err=0.
- Output register:
  - Single stage, so the latency from flit accept to valid is 1 cycle.
  - in_ready = (~valid | ready) & ~vc_free[in_vc] & (credit[in_vc] != 0). This is combinational.
  - Accept = in_valid & in_ready. On accept, data is loaded with in_data, except bits [DW-3:DW-4] are replaced by in_vc; valid is set to 1.
  - If ready is high and there is no accept, valid is cleared to 0.
  - While valid=1 and ready=0, data and valid hold stable. This allows back-to-back flits at full rate.
- Credits:
  - Accept into VC v decrements credit[v].
  - A credit_in[v] pulse increments credit[v].
  - Both in the same cycle on the same VC: credit[v] is unchanged.
  - A credit_in[v] pulse while credit[v]==BUF_DEPTH with no accept on v: the counter saturates (stays at BUF_DEPTH) and err is set to 1.
- VC ownership, per VC, two states:
  - FREE to OWNED on alloc_valid with alloc_vc==v while vc_free[v]==1.
  - OWNED to FREE on accept of a tail or head-tail flit on v. vc_free[v] rises the following cycle.
  - An alloc to a VC that is OWNED is ignored and sets err to 1.
  - A tail accept on v and an alloc to v in the same cycle cannot legally occur, because vc_free[v] is still 0 that cycle. The alloc is ignored and err is set to 1.
- Other errors:
  - in_valid to a FREE VC: no accept, and err is set to 1.
  - Flits to a VC that has no credit simply stall. This is not an error.
- Ordering: the stage holds at most one flit and does not reorder. Flits leave in accept order.
- rst mid-packet: all state returns to reset values in the same cycle. An in-flight flit in the register is dropped (valid goes to 0). Credits reload to BUF_DEPTH, so the downstream must be reset at the same time.

Test Plan:
- After reset:
  - alloc VC2, then send a head/body/tail packet on VC2 with ready=1.
  - Required: the three flits appear on consecutive cycles, each with data[DW-3:DW-4]=2'b10.
  - vc_free[2] is 0 after the alloc and returns to 1 the cycle after the tail is accepted.
  - credit[2] goes 4,3,2,1.
- Stream 5 flits on VC0 with no credit_in:
  - Required: 4 flits are accepted; vc_has_credit[0]=0; in_ready=0 for the 5th.
  - One credit_in[0] pulse, then the 5th flit is accepted the next cycle.
- Backpressure: hold ready=0 with valid=1 for 3 cycles.
  - Required: data is stable and in_ready=0.
  - When ready=1, a flit is accepted the same cycle, and valid stays 1 with the new data.
- Simultaneous credit_in[1] and accept on VC1 with credit[1]=2:
  - Required: credit[1] stays 2.
  - A credit_in[3] pulse at credit[3]=4 gives err=1 with credit[3] remaining 4.
- Error cases:
  - alloc VC1 twice gives err=1.
  - in_valid to FREE VC3 gives in_ready=0 and err=1.
  - Only rst clears err.
- rst asserted while valid=1 mid-packet:
  - Required: next cycle valid=0, all vc_free=1, all credits=4.
